// File: rtl/pipeline_sched_ctrl_pkg.sv
// Shared definitions for the pipeline scheduling controller: FSM state
// encodings, the hard-wired zero register and default parameter values.
package pipeline_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_CNT_W       = 16;
    localparam int         DEF_MEM_TIMEOUT = 8;

endpackage

// File: rtl/pipeline_sched_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush/wait performance counters.
// Sticks at all-ones instead of wrapping so long runs never under-report.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] q_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count up on inc_i, hold once the maximum value is reached
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign q_o = r_count;

endmodule

// File: rtl/pipeline_sched_ctrl.sv
// Central sequencer for the 5-stage pipeline. Resolves memory waits,
// load-use stalls and taken-branch flushes by fixed priority and drives
// all pipeline-register enables. Control outputs are combinational from
// the current state and hazard inputs; state and counters are registered.
module pipeline_sched_ctrl
    import pipeline_sched_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_branch_i,
    input  logic             id_taken_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [1:0]       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic             r_err;
    logic [CNT_W-1:0] r_consecWait;

    logic w_active;
    logic w_memStall;
    logic w_loadUse;
    logic w_branchTaken;
    logic w_stallInc;
    logic w_flushInc;
    logic w_waitInc;

    assign w_active      = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
    assign w_memStall    = mem_req_i & ~dmem_ready_i;
    assign w_loadUse     = ex_memread_i & (ex_rt_i != REG_ZERO) &
                           ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
    assign w_branchTaken = id_branch_i & id_taken_i;

    assign w_waitInc  = w_active & w_memStall;
    assign w_stallInc = w_active & ~w_memStall & w_loadUse;
    assign w_flushInc = w_active & ~w_memStall & ~w_loadUse & w_branchTaken;

    // Hazard priority mux: memory stall, then load-use, then branch flush
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_flush_o     = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b1;
        if (w_active) begin
            if (w_memStall) begin
                pipe_freeze_o = 1'b1;
            end else if (w_loadUse) begin
                pipe_freeze_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end else if (w_branchTaken) begin
                pipe_freeze_o = 1'b0;
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
                if_flush_o    = 1'b1;
            end else begin
                pipe_freeze_o = 1'b0;
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
            end
        end
    end

    // Sequencer FSM with memory-wait timeout tracking and sticky error flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_err        <= 1'b0;
            r_consecWait <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_memStall) begin
                        r_state      <= ST_MEM_WAIT;
                        r_consecWait <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_memStall) begin
                        if (r_consecWait == TIMEOUT_LAST) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else begin
                            r_consecWait <= r_consecWait + 1'b1;
                        end
                    end else if (start_i) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign err_o   = r_err;

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stallInc),
        .clr_i (1'b0),
        .q_o   (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_flushInc),
        .clr_i (1'b0),
        .q_o   (flush_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_waitCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_waitInc),
        .clr_i (1'b0),
        .q_o   (wait_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_sched_ctrl.sv
// Scoreboard bench for pipeline_sched_ctrl. Each driven cycle pushes its
// hand-computed expected outputs; a monitor pops and compares on the
// falling edge, in the middle of the cycle the inputs were driven.
module tb_pipeline_sched_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 8;

    localparam logic [4:0] CTL_IDLE  = 5'b00001;
    localparam logic [4:0] CTL_RUN   = 5'b11000;
    localparam logic [4:0] CTL_STALL = 5'b00010;
    localparam logic [4:0] CTL_FLUSH = 5'b11100;
    localparam logic [4:0] CTL_MEM   = 5'b00001;

    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [1:0] state;
        logic       err;
        logic [3:0] stall;
        logic [3:0] flush;
        logic [3:0] waitc;
    } expVec_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [4:0]       id_rs_i = '0;
    logic [4:0]       id_rt_i = '0;
    logic             id_branch_i = 1'b0;
    logic             id_taken_i = 1'b0;
    logic             ex_memread_i = 1'b0;
    logic [4:0]       ex_rt_i = '0;
    logic             mem_req_i = 1'b0;
    logic             dmem_ready_i = 1'b0;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_flush_o;
    logic             id_ex_bubble_o;
    logic             pipe_freeze_o;
    logic [1:0]       state_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] wait_cnt_o;

    expVec_t expQ[$];
    int      checks = 0;
    int      failures = 0;

    pipeline_sched_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_branch_i    (id_branch_i),
        .id_taken_i     (id_taken_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rt_i        (ex_rt_i),
        .mem_req_i      (mem_req_i),
        .dmem_ready_i   (dmem_ready_i),
        .pc_write_o     (pc_write_o),
        .if_id_write_o  (if_id_write_o),
        .if_flush_o     (if_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .pipe_freeze_o  (pipe_freeze_o),
        .state_o        (state_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .wait_cnt_o     (wait_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(
        input string name, input logic start, input logic [4:0] rs, input logic [4:0] rt,
        input logic br, input logic tk, input logic mr, input logic [4:0] exrt,
        input logic mreq, input logic rdy, input logic [4:0] ctl, input logic [1:0] st,
        input logic err, input logic [3:0] stallc, input logic [3:0] flushc, input logic [3:0] waitc);
        expVec_t e;
        @(posedge clk_i);
        #1;
        start_i      = start;
        id_rs_i      = rs;
        id_rt_i      = rt;
        id_branch_i  = br;
        id_taken_i   = tk;
        ex_memread_i = mr;
        ex_rt_i      = exrt;
        mem_req_i    = mreq;
        dmem_ready_i = rdy;
        e.name  = name;
        e.ctl   = ctl;
        e.state = st;
        e.err   = err;
        e.stall = stallc;
        e.flush = flushc;
        e.waitc = waitc;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk_i);
        #1;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        id_rs_i      = '0;
        id_rt_i      = '0;
        id_branch_i  = 1'b0;
        id_taken_i   = 1'b0;
        ex_memread_i = 1'b0;
        ex_rt_i      = '0;
        mem_req_i    = 1'b0;
        dmem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Monitor: one expected entry is consumed per falling edge
    initial begin
        expVec_t e;
        forever begin
            @(negedge clk_i);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, ".pc_write"},  16'(pc_write_o),     16'(e.ctl[4]));
                checkOutput({e.name, ".if_id_write"}, 16'(if_id_write_o), 16'(e.ctl[3]));
                checkOutput({e.name, ".if_flush"},  16'(if_flush_o),     16'(e.ctl[2]));
                checkOutput({e.name, ".bubble"},    16'(id_ex_bubble_o), 16'(e.ctl[1]));
                checkOutput({e.name, ".freeze"},    16'(pipe_freeze_o),  16'(e.ctl[0]));
                checkOutput({e.name, ".state"},     16'(state_o),        16'(e.state));
                checkOutput({e.name, ".err"},       16'(err_o),          16'(e.err));
                checkOutput({e.name, ".stall_cnt"}, 16'(stall_cnt_o),    16'(e.stall));
                checkOutput({e.name, ".flush_cnt"}, 16'(flush_cnt_o),    16'(e.flush));
                checkOutput({e.name, ".wait_cnt"},  16'(wait_cnt_o),     16'(e.waitc));
            end
        end
    end

    // Directed stimulus
    initial begin
        int guard;
        $display("[TB] starting pipeline_sched_ctrl bench");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE, 2'd0, 0, 0, 0, 0);
        applyStimulus("start_raise",    1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 0, 0, 0);
        applyStimulus("run_normal",     1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN,   2'd1, 0, 0, 0, 0);
        applyStimulus("loaduse_rs",     1, 8, 0, 0, 0, 1, 8, 0, 0, CTL_STALL, 2'd1, 0, 0, 0, 0);
        applyStimulus("after_loaduse",  1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN,   2'd1, 0, 1, 0, 0);
        applyStimulus("reg_zero",       1, 0, 0, 0, 0, 1, 0, 0, 0, CTL_RUN,   2'd1, 0, 1, 0, 0);
        applyStimulus("loaduse_rt",     1, 3, 5, 0, 0, 1, 5, 0, 0, CTL_STALL, 2'd1, 0, 1, 0, 0);
        applyStimulus("branch_taken",   1, 0, 0, 1, 1, 0, 0, 0, 0, CTL_FLUSH, 2'd1, 0, 2, 0, 0);
        applyStimulus("branch_vs_lu",   1, 7, 7, 1, 1, 1, 7, 0, 0, CTL_STALL, 2'd1, 0, 2, 1, 0);
        applyStimulus("branch_not_tk",  1, 0, 0, 1, 0, 0, 0, 0, 0, CTL_RUN,   2'd1, 0, 3, 1, 0);
        applyStimulus("mem_stall_run",  1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd1, 0, 3, 1, 0);
        applyStimulus("mem_wait_a",     1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd2, 0, 3, 1, 1);
        applyStimulus("mem_wait_b",     1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd2, 0, 3, 1, 2);
        applyStimulus("mem_ready",      1, 0, 0, 0, 0, 0, 0, 1, 1, CTL_RUN,   2'd2, 0, 3, 1, 3);
        applyStimulus("after_mem",      1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN,   2'd1, 0, 3, 1, 3);
        applyStimulus("mem_over_all",   1, 8, 8, 1, 1, 1, 8, 1, 0, CTL_MEM,   2'd1, 0, 3, 1, 3);
        applyStimulus("wait_start_low", 0, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd2, 0, 3, 1, 4);
        applyStimulus("ready_start_low",0, 0, 0, 0, 0, 0, 0, 1, 1, CTL_RUN,   2'd2, 0, 3, 1, 5);
        applyStimulus("back_to_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 3, 1, 5);
        applyStimulus("restart",        1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 3, 1, 5);
        applyStimulus("run_start_low",  0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN,   2'd1, 0, 3, 1, 5);
        applyStimulus("idle_hold",      0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 3, 1, 5);

        doReset();
        applyStimulus("to_start",       1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 0, 0, 0);
        applyStimulus("to_stall_run",   1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd1, 0, 0, 0, 0);
        for (int k = 1; k <= MEM_TIMEOUT; k++)
            applyStimulus($sformatf("to_wait%0d", k), 1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM, 2'd2, 0, 0, 0, 4'(k));
        applyStimulus("error_entry",    1, 8, 8, 1, 1, 1, 8, 1, 1, CTL_IDLE,  2'd3, 1, 0, 0, 9);
        applyStimulus("error_hold_a",   1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd3, 1, 0, 0, 9);
        applyStimulus("error_hold_b",   1, 0, 0, 1, 1, 0, 0, 0, 0, CTL_IDLE,  2'd3, 1, 0, 0, 9);

        doReset();
        applyStimulus("sat_start",      1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 0, 0, 0);
        for (int j = 0; j < 20; j++)
            applyStimulus($sformatf("sat_lu%0d", j), 1, 9, 0, 0, 0, 1, 9, 0, 0, CTL_STALL, 2'd1, 0,
                          (j < 15) ? 4'(j) : 4'd15, 0, 0);
        applyStimulus("sat_hold",       1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN,   2'd1, 0, 15, 0, 0);
        applyStimulus("sat_mem_run",    1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd1, 0, 15, 0, 0);
        applyStimulus("sat_mem_wait",   1, 0, 0, 0, 0, 0, 0, 1, 0, CTL_MEM,   2'd2, 0, 15, 0, 1);

        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst.state",    16'(state_o),       16'd0);
        checkOutput("async_rst.stall",    16'(stall_cnt_o),   16'd0);
        checkOutput("async_rst.flush",    16'(flush_cnt_o),   16'd0);
        checkOutput("async_rst.wait",     16'(wait_cnt_o),    16'd0);
        checkOutput("async_rst.err",      16'(err_o),         16'd0);
        checkOutput("async_rst.pc_write", 16'(pc_write_o),    16'd0);
        checkOutput("async_rst.freeze",   16'(pipe_freeze_o), 16'd1);
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b0;
        mem_req_i = 1'b0;
        applyStimulus("post_rst_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_IDLE,  2'd0, 0, 0, 0, 0);

        guard = 0;
        while ((expQ.size() > 0) && (guard < 20)) begin
            @(negedge clk_i);
            #1;
            guard++;
        end
        checkOutput("scoreboard_drain", 16'(expQ.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
